// File: rtl/bcd_digit_scanner.sv
// Scans a packed BCD frame one digit per beat, most significant first, and
// maps each digit onto a bank select / in-bank address pair for a segment store.
//
//  state | meaning
//  IDLE  | waiting for start; last frame_err held
//  LOAD  | frame captured; first beat being prepared
//  EMIT  | beat presented on out_valid, held until accepted
//  DONE  | one-cycle completion pulse
module bcd_digit_scanner #(
    parameter int NUM_DIGITS = 6,
    parameter int ADDR_W     = 2,
    parameter int SEL_W      = 4,
    parameter int SEL_BASE   = 4,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_vec,
    input  logic                    blank_lz,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        digit_idx,
    output logic [ADDR_W-1:0]       address_out,
    output logic [SEL_W-1:0]        sel_address_out,
    output logic                    digit_err,
    output logic                    frame_err,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] vec_q;
    logic                    blank_q;
    logic                    lz_q;

    logic [3:0]              digits [NUM_DIGITS];
    logic [IDX_W-1:0]        beat_idx;
    logic                    beat_lz;
    logic [3:0]              beat_digit;
    logic                    beat_err;
    logic                    beat_blank;
    logic [ADDR_W-1:0]       beat_addr;
    logic [SEL_W-1:0]        beat_sel;
    logic                    handshake;
    logic                    load_beat;

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == LOAD) || (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign handshake = out_valid && out_ready;
    assign load_beat = enable && ((state_q == LOAD) || (handshake && (digit_idx != '0)));

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = vec_q[4*i +: 4];
        end
    end

    // The beat registered at the next edge: the first digit from LOAD, else the next lower one.
    always_comb begin
        beat_idx   = (state_q == LOAD) ? IDX_W'(NUM_DIGITS - 1) : digit_idx - IDX_W'(1);
        beat_lz    = (state_q == LOAD) ? blank_q : lz_q;
        beat_digit = digits[beat_idx];
        beat_err   = (beat_digit > 4'd9);
        beat_blank = beat_lz && (beat_digit == 4'd0) && (beat_idx != '0);
        beat_addr  = '0;
        beat_sel   = '0;
        if (!beat_err && !beat_blank) begin
            beat_addr = ADDR_W'(beat_digit);
            beat_sel  = SEL_W'(SEL_BASE) + SEL_W'(beat_digit >> ADDR_W);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = EMIT;
            EMIT: if (handshake && (digit_idx == '0)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q           <= '0;
            blank_q         <= 1'b0;
            lz_q            <= 1'b0;
            digit_idx       <= '0;
            address_out     <= '0;
            sel_address_out <= '0;
            digit_err       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start && enable) begin
                vec_q     <= bcd_vec;
                blank_q   <= blank_lz;
                frame_err <= 1'b0;
            end
            if (load_beat) begin
                digit_idx       <= beat_idx;
                address_out     <= beat_addr;
                sel_address_out <= beat_sel;
                digit_err       <= beat_err;
                lz_q            <= beat_blank;
                if (beat_err) frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner: expected beats are queued when a frame
// is started and checked against each accepted beat.
module tb_bcd_digit_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [23:0] bcd_vec = '0;
    logic        blank_lz = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [2:0]  digit_idx;
    logic [1:0]  address_out;
    logic [3:0]  sel_address_out;
    logic        digit_err;
    logic        frame_err;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] sel;
        logic [1:0] addr;
        logic       err;
        logic       ferr;
    } beat_t;

    beat_t q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    done_count = 0;
    int    done_cyc = 0;
    logic  have_hold = 1'b0;
    logic [9:0] held = '0;

    bcd_digit_scanner dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .bcd_vec(bcd_vec), .blank_lz(blank_lz), .out_ready(out_ready),
        .out_valid(out_valid), .digit_idx(digit_idx), .address_out(address_out),
        .sel_address_out(sel_address_out), .digit_err(digit_err),
        .frame_err(frame_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue the first n beats of a frame.
    task automatic push_frame(input logic [23:0] vec, input logic blank, input int n);
        logic       lz;
        logic       ferr;
        logic [3:0] d;
        beat_t      b;
        lz = blank;
        ferr = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            d = vec[4*i +: 4];
            b.idx = 3'(i);
            b.err = 1'b0;
            b.sel = 4'd0;
            b.addr = 2'd0;
            if (d > 4'd9) begin
                b.err = 1'b1;
                ferr = 1'b1;
                lz = 1'b0;
            end else if (lz && d == 4'd0 && i > 0) begin
                lz = 1'b1;
            end else begin
                b.sel = 4'd4 + 4'(d / 4);
                b.addr = 2'(d % 4);
                lz = 1'b0;
            end
            b.ferr = ferr;
            if (5 - i < n) q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'({digit_idx, sel_address_out, address_out, digit_err}), 32'(held));
            end
            have_hold = out_valid && !out_ready && enable;
            held = {digit_idx, sel_address_out, address_out, digit_err};
            if (out_valid && out_ready && enable) begin
                hs_count++;
                check("beat_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0)
                    check("beat", 32'({digit_idx, sel_address_out, address_out, digit_err, frame_err}),
                          32'(q.pop_front()));
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_frame(input logic [23:0] vec, input logic blank, input logic toggle,
                             input logic mid_start);
        int hs0, dc0, c0;
        push_frame(vec, blank, 6);
        hs0 = hs_count;
        dc0 = done_count;
        out_ready = 1'b1;
        @(posedge clk); #1;
        bcd_vec = vec; blank_lz = blank; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; bcd_vec = 24'hFFFFFF; blank_lz = ~blank;
        check("load_busy", 32'(busy), 32'd1);
        check("ferr_clear_on_start", 32'(frame_err), 32'd0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            if (mid_start && k == 0) begin start = 1'b1; bcd_vec = 24'h999999; end
            if (mid_start && k == 1) start = 1'b0;
            if (done_count != dc0) break;
        end
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("done_pulses", 32'(done_count - dc0), 32'd1);
        check("handshakes", 32'(hs_count - hs0), 32'd6);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("idle_after", 32'({busy, out_valid}), 32'd0);
        if (!toggle) check("done_latency", 32'(done_cyc - c0), 32'd9);
    endtask

    initial begin
        int hs0, dc0;
        #3;
        check("reset_outputs", 32'({out_valid, busy, done, digit_idx, address_out,
                                    sel_address_out, digit_err, frame_err}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        check("idle_no_valid", 32'({out_valid, busy, done}), 32'd0);

        run_frame(24'h123459, 1'b0, 1'b0, 1'b0);
        run_frame(24'h000070, 1'b1, 1'b0, 1'b0);
        run_frame(24'h000000, 1'b1, 1'b0, 1'b0);
        run_frame(24'h12A456, 1'b0, 1'b0, 1'b0);
        check("ferr_sticky", 32'(frame_err), 32'd1);
        run_frame(24'h123459, 1'b0, 1'b1, 1'b0);
        run_frame(24'h987654, 1'b0, 1'b0, 1'b1);

        // enable dropped while the third beat is presented
        push_frame(24'h123459, 1'b0, 2);
        hs0 = hs_count; dc0 = done_count;
        @(posedge clk); #1;
        bcd_vec = 24'h123459; blank_lz = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; enable = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 32'({out_valid, busy}), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(done_count - dc0), 32'd0);
        check("abort_handshakes", 32'(hs_count - hs0), 32'd2);
        check("abort_queue", 32'(q.size()), 32'd0);
        enable = 1'b1; out_ready = 1'b1;

        // reset pulsed while the second beat is presented
        push_frame(24'h123459, 1'b0, 1);
        hs0 = hs_count; dc0 = done_count;
        @(posedge clk); #1;
        bcd_vec = 24'h123459; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1; out_ready = 1'b0;
        #1;
        check("reset_async", 32'({out_valid, busy, done, digit_idx, address_out,
                                  sel_address_out, digit_err, frame_err}), 32'd0);
        @(posedge clk); #1; reset = 1'b0; out_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("reset_waits", 32'({busy, out_valid}), 32'd0);
        check("reset_handshakes", 32'(hs_count - hs0), 32'd1);
        check("reset_no_done", 32'(done_count - dc0), 32'd0);
        check("reset_queue", 32'(q.size()), 32'd0);
        run_frame(24'h987654, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bcd_digit_scanner.md
BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of BCD digits per frame (1..16).
REQ-002 Parameter ADDR_W, default 2: width of the in-bank address; one bank holds 2^ADDR_W digits.
REQ-003 Parameter SEL_W, default 4: width of the bank select output.
REQ-004 Parameter SEL_BASE, default 4: bank select value for digit 0; SEL_BASE + 9/2^ADDR_W SHALL fit in SEL_W bits.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1: clock, all state updates on rising edge.
REQ-007 reset  input  1: asynchronous active-high reset.
REQ-008 enable  input  1: block enable; low aborts any frame.
REQ-009 start  input  1: one-cycle frame request, sampled in IDLE only.
REQ-010 bcd_vec  input  4*NUM_DIGITS: packed digits; digit NUM_DIGITS-1 in the top nibble, emitted first.
REQ-011 blank_lz  input  1: leading-zero blanking mode, sampled with start.
REQ-012 out_ready  input  1: consumer accepts the current beat.
REQ-013 out_valid  output  1: beat valid.
REQ-014 digit_idx  output  clog2(NUM_DIGITS): position of the current beat (NUM_DIGITS-1 down to 0).
REQ-015 address_out  output  ADDR_W: in-bank address.
REQ-016 sel_address_out  output  SEL_W: bank select; 0 means blank.
REQ-017 digit_err  output  1: current beat carries an invalid digit (>9).
REQ-018 frame_err  output  1: sticky; any invalid digit in the last/current frame.
REQ-019 busy  output  1: high in LOAD and EMIT.
REQ-020 done  output  1: one-cycle pulse at frame completion.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, EMIT, DONE.
REQ-022 IDLE -> LOAD when start && enable; bcd_vec and blank_lz SHALL be captured that cycle; frame_err cleared.
REQ-023 LOAD -> EMIT after exactly one cycle; index set to NUM_DIGITS-1, leading-zero flag set to captured blank_lz.
REQ-024 In EMIT, out_valid SHALL be 1 and address_out/sel_address_out/digit_idx/digit_err SHALL be registered and stable until out_valid && out_ready.
REQ-025 Valid digit d SHALL map to address_out = d mod 2^ADDR_W, sel_address_out = SEL_BASE + d / 2^ADDR_W (defaults: 0..3 -> sel 4, 4..7 -> sel 5, 8..9 -> sel 6).
REQ-026 Digit >9 SHALL emit address_out=0, sel_address_out=0, digit_err=1, and set frame_err.
REQ-027 While the leading-zero flag is set, a zero digit at idx>0 SHALL emit sel_address_out=0, address_out=0; the first nonzero digit or idx 0 clears the flag; digit 0 at idx 0 is never blanked.
REQ-028 On handshake with idx>0, idx SHALL decrement and the next beat SHALL be presented the following cycle (throughput one beat per cycle with out_ready held high).
REQ-029 On handshake with idx=0, EMIT -> DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-030 start while busy or in DONE SHALL be ignored.
REQ-031 enable low in any state SHALL force IDLE on the next edge, out_valid=0, no done pulse; frame_err keeps its value.
REQ-032 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-033 reset high SHALL immediately force IDLE, out_valid=0, digit_idx=0, address_out=0, sel_address_out=0, digit_err=0, frame_err=0, busy=0, done=0.
REQ-034 reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a new start.

Verification
REQ-035 Defaults, bcd_vec=0x123459, blank_lz=0, out_ready=1 -> 6 consecutive beats (sel,addr)=(4,1)(4,2)(4,3)(5,0)(5,1)(6,1), idx 5..0, done 2 cycles after the last beat edge... one cycle after last handshake.
REQ-036 bcd_vec=0x000070, blank_lz=1 -> beats sel 0,0,0,0 then (5,3),(4,0); bcd_vec=0x000000, blank_lz=1 -> five blanks then (4,0).
REQ-037 bcd_vec=0x12A456 -> third beat sel=0 addr=0 digit_err=1; frame_err=1 from that beat until next start.
REQ-038 out_ready toggled 1/0 per cycle -> each beat held stable while not accepted; exactly 6 handshakes, no beat skipped or duplicated.
REQ-039 enable dropped during beat 3 -> out_valid=0 next cycle, IDLE, no done; start asserted during EMIT -> ignored, frame unaffected.
REQ-040 reset pulsed during beat 2 -> all outputs 0 asynchronously; following start with 0x987654 -> full correct frame (6,1)(6,0)(5,3)(5,2)(5,1)(5,0).
